// File: rtl/riscv_boot_pkg.sv
// Shared types for the instruction-memory boot loader.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package riscv_boot_pkg;

  // Loader FSM states, in frame order followed by the two terminal states.
  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } boot_state_e;

  // Frame start marker.
  localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

  // Word count carried in the frame header.
  typedef logic [15:0] frame_len_t;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs bytes LSB-first into 32-bit words and presents each finished word for one cycle.
// Latency: word_vld/word_dat registered, one cycle after the edge that takes the 4th byte.
// Backpressure: none; the output word register is separate from the shift register,
//   so a byte may enter while the previous word is still being presented.
// Ports: clk/rst_n; clr restarts byte alignment; byte_vld/byte_dat input byte;
//        word_cmpl flags the current byte as the 4th of a word; word_vld/word_dat output word.
module boot_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_cmpl,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        word_vld_q, word_vld_d;
  logic [31:0] word_q, word_d;

  assign word_cmpl = byte_vld && !clr && (cnt_q == 2'd3);

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word_vld_d = 1'b0;
    word_d     = word_q;
    if (clr) begin
      cnt_d = 2'd0;
    end else if (byte_vld) begin
      if (cnt_q == 2'd3) begin
        // Earlier bytes sit in the low positions, newest byte becomes bits [31:24].
        word_d     = {byte_dat, shift_q};
        word_vld_d = 1'b1;
        cnt_d      = 2'd0;
      end else begin
        shift_d = {byte_dat, shift_q[23:8]};
        cnt_d   = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 2'd0;
      shift_q    <= 24'd0;
      word_vld_q <= 1'b0;
      word_q     <= 32'd0;
    end else begin
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      word_vld_q <= word_vld_d;
      word_q     <= word_d;
    end
  end

  assign word_vld = word_vld_q;
  assign word_dat = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a framed byte stream, writes it as little-endian words into instruction memory, releases core reset on a good checksum.
// Latency: imem_we one cycle after the edge accepting a word's 4th byte; core_rst_n rises one edge after DONE entry.
// Backpressure: in_ready high in every state except DONE, which stalls the stream until rst_n.
// Ports: clk/rst_n; in_valid/in_data/in_ready byte stream; imem_we/imem_addr/imem_wdata memory write;
//        core_rst_n reset to the core (low = held); load_done sticky success; load_err last frame failed.
module imem_boot_loader
  import riscv_boot_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 4096,
  parameter int unsigned IMEM_AW    = $clog2(IMEM_DEPTH),
  parameter logic [7:0]  SYNC_BYTE  = BOOT_SYNC_BYTE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst_n,
  output logic               load_done,
  output logic               load_err
);

  boot_state_e        state_q, state_d;
  frame_len_t         len_q, len_d;
  frame_len_t         wcnt_q, wcnt_d;
  logic [7:0]         sum_q, sum_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic               in_ready_q, in_ready_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               load_done_q, load_done_d;
  logic               load_err_q, load_err_d;

  logic       accept;
  logic       asm_clr;
  logic       asm_vld;
  logic       asm_cmpl;
  frame_len_t len_full;

  assign accept   = in_valid && in_ready_q;
  assign len_full = {in_data, len_q[7:0]};

  boot_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (asm_clr),
    .byte_vld  (asm_vld),
    .byte_dat  (in_data),
    .word_cmpl (asm_cmpl),
    .word_vld  (imem_we),
    .word_dat  (imem_wdata)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    asm_clr = 1'b0;
    asm_vld = 1'b0;
    if (accept) begin
      unique case (state_q)
        SYNC: begin
          if (in_data == SYNC_BYTE) state_d = LEN0;
        end
        LEN0: begin
          len_d   = {8'h00, in_data};
          state_d = LEN1;
        end
        LEN1: begin
          len_d   = len_full;
          wcnt_d  = '0;
          sum_d   = 8'h00;
          asm_clr = 1'b1;
          if ({16'h0000, len_full} > IMEM_DEPTH) state_d = ERROR;
          else if (len_full == '0)               state_d = CSUM;
          else                                   state_d = DATA;
        end
        DATA: begin
          asm_vld = 1'b1;
          sum_d   = sum_q + in_data;
          if (asm_cmpl) begin
            // Address is captured now so it lines up with the assembler's
            // registered word on the following cycle.
            addr_d = wcnt_q[IMEM_AW-1:0];
            wcnt_d = wcnt_q + 16'd1;
            // The last word's write strobe lands in the first CSUM cycle,
            // so the checksum byte may already be taken alongside it.
            if (wcnt_q == len_q - 16'd1) state_d = CSUM;
          end
        end
        CSUM: begin
          state_d = (in_data == sum_q) ? DONE : ERROR;
        end
        DONE: begin
          state_d = DONE;
        end
        ERROR: begin
          if (in_data == SYNC_BYTE) state_d = LEN0;
        end
        default: state_d = SYNC;
      endcase
    end
    in_ready_d   = (state_d != DONE);
    load_done_d  = (state_d == DONE);
    load_err_d   = (state_d == ERROR);
    // One edge behind DONE entry; DONE is only left through rst_n, so this stays high.
    core_rst_n_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SYNC;
      len_q        <= '0;
      wcnt_q       <= '0;
      sum_q        <= 8'h00;
      addr_q       <= '0;
      in_ready_q   <= 1'b1;
      core_rst_n_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      sum_q        <= sum_d;
      addr_q       <= addr_d;
      in_ready_q   <= in_ready_d;
      core_rst_n_q <= core_rst_n_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_addr  = addr_q;
  assign core_rst_n = core_rst_n_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frame vectors, timing corner sequences and random frames vs a frame-level model.
// Latency: checks each write one cycle after its 4th data byte and core_rst_n one cycle after the checksum byte.
// Backpressure: in_ready sampled every byte; DONE must refuse further bytes.
module tb_imem_boot_loader;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          load_done;
  logic          load_err;

  imem_boot_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [7:0] b; int cyc; } ac_t;
  typedef struct { int addr; logic [31:0] data; int idx; } ex_t;
  typedef struct { bit rst; int len; logic [127:0] bv; int nw; bit done; bit err; } vec_t;

  wr_t wq[$];
  ac_t aq[$];
  ex_t exp_q[$];
  bit  exp_done;
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;

  // Observe writes and accepted bytes on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    cyc++;
    if (imem_we) wq.push_back('{int'(imem_addr), imem_wdata, cyc});
    if (in_valid && in_ready) aq.push_back('{in_data, cyc});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Frame-level reference: find the marker, read the length, cut the data into
  // little-endian words and compare the trailing byte to the mod-256 byte sum.
  task automatic model_frame(input logic [7:0] fb[$]);
    int i, n;
    logic [7:0]  s;
    logic [31:0] wd;
    exp_q.delete();
    exp_done = 1'b0;
    i = 0;
    while (i < fb.size() && fb[i] != 8'hA5) i++;
    if (i + 2 >= fb.size()) return;
    n = int'(fb[i+1]) + 256 * int'(fb[i+2]);
    i += 3;
    if (n > DEPTH) return;
    s = 8'h00;
    for (int w = 0; w < n; w++) begin
      wd = {fb[i+3], fb[i+2], fb[i+1], fb[i]};
      s  = s + fb[i] + fb[i+1] + fb[i+2] + fb[i+3];
      exp_q.push_back('{w, wd, i + 3});
      i += 4;
    end
    exp_done = (i < fb.size()) && (fb[i] == s);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    ok = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk("send_ready_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] fb[$], input bit gaps, input string nm);
    int nbad;
    model_frame(fb);
    wq.delete();
    aq.delete();
    foreach (fb[i]) send_byte(fb[i], gaps);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk({nm, "_acc_cnt"}, aq.size(), fb.size());
    nbad = 0;
    for (int i = 0; i < aq.size() && i < fb.size(); i++) if (aq[i].b !== fb[i]) nbad++;
    chk({nm, "_acc_bytes_bad"}, nbad, 0);
    chk({nm, "_wr_cnt"}, wq.size(), exp_q.size());
    for (int w = 0; w < wq.size() && w < exp_q.size(); w++) begin
      chk($sformatf("%s_wr%0d_addr", nm, w), wq[w].addr, exp_q[w].addr);
      chk($sformatf("%s_wr%0d_data", nm, w), wq[w].data, exp_q[w].data);
      if (exp_q[w].idx < aq.size())
        chk($sformatf("%s_wr%0d_lat", nm, w), wq[w].cyc - aq[exp_q[w].idx].cyc, 1);
    end
    chk({nm, "_load_done"},  load_done,  exp_done);
    chk({nm, "_load_err"},   load_err,   !exp_done);
    chk({nm, "_core_rst_n"}, core_rst_n, exp_done);
    chk({nm, "_in_ready"},   in_ready,   !exp_done);
  endtask

  task automatic build_frame(input int n, input bit corrupt, input int ng, output logic [7:0] q[$]);
    logic [7:0] s, d;
    q.delete();
    s = 8'h00;
    repeat (ng) begin
      d = 8'($urandom_range(0, 255));
      if (d == 8'hA5) d = 8'h00;
      q.push_back(d);
    end
    q.push_back(8'hA5);
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      d = 8'($urandom);
      q.push_back(d);
      s = s + d;
    end
    q.push_back(corrupt ? s + 8'd1 : s);
  endtask

  vec_t       vt[8];
  logic [7:0] fb[$];
  bit         last_done;
  int         nacc;

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",   in_ready,   1'b1);
    chk("rst_imem_we",    imem_we,    1'b0);
    chk("rst_imem_addr",  imem_addr,  '0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_core_rst_n", core_rst_n, 1'b0);
    chk("rst_load_done",  load_done,  1'b0);
    chk("rst_load_err",   load_err,   1'b0);
    do_reset();

    // Frame vectors: {reset first, byte count, bytes (first byte most significant), writes, done, err}.
    vt[0] = '{1'b1, 12, 128'hA5020013_05A00093_05B00000, 2, 1'b1, 1'b0};
    vt[1] = '{1'b1, 12, 128'hA5020013_05A00093_05B00001, 2, 1'b0, 1'b1};
    vt[2] = '{1'b0, 12, 128'hA5020013_05A00093_05B00000, 2, 1'b1, 1'b0};
    vt[3] = '{1'b1, 15, 128'h00FF5A_A5020013_05A00093_05B00000, 2, 1'b1, 1'b0};
    vt[4] = '{1'b1, 3,  128'hA50110, 0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 4,  128'hA5000000, 0, 1'b1, 1'b0};
    vt[6] = '{1'b1, 4,  128'hA5000001, 0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 14, 128'h1122_A5020013_05A00093_05B00000, 2, 1'b1, 1'b0};

    for (int v = 0; v < 8; v++) begin
      fb.delete();
      for (int i = 0; i < vt[v].len; i++) fb.push_back(vt[v].bv[8*(vt[v].len-1-i) +: 8]);
      if (vt[v].rst) do_reset();
      run_frame(fb, 1'b0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_tbl_nwr", v),  wq.size(), vt[v].nw);
      chk($sformatf("vec%0d_tbl_done", v), load_done, vt[v].done);
      chk($sformatf("vec%0d_tbl_err", v),  load_err,  vt[v].err);
      if (v == 0 && wq.size() == 2) begin
        chk("vec0_word0", wq[0].data, 32'h00A00513);
        chk("vec0_word1", wq[1].data, 32'h00B00593);
      end
    end

    // core_rst_n releases exactly one edge after the checksum byte is taken.
    do_reset();
    fb.delete();
    for (int i = 0; i < 12; i++) fb.push_back(vt[0].bv[8*(11-i) +: 8]);
    foreach (fb[i]) send_byte(fb[i], 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("csum_edge_load_done",  load_done,  1'b1);
    chk("csum_edge_core_rst_n", core_rst_n, 1'b0);
    @(negedge clk);
    chk("csum_next_core_rst_n", core_rst_n, 1'b1);
    @(posedge clk); #1;

    // Maximum length image: last write at the top address.
    do_reset();
    build_frame(DEPTH, 1'b0, 0, fb);
    run_frame(fb, 1'b0, "full");
    if (wq.size() > 0) chk("full_last_addr", wq[wq.size()-1].addr, DEPTH - 1);

    // Four words with a byte offered on every cycle.
    do_reset();
    build_frame(4, 1'b0, 0, fb);
    run_frame(fb, 1'b0, "b2b4");
    chk("b2b4_nwr", wq.size(), 4);

    // Reset asserted while the first word's write strobe is high.
    do_reset();
    fb.delete();
    fb = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (fb[i]) send_byte(fb[i], 1'b0);
    in_valid = 1'b0;
    #1;
    chk("midrst_pre_we",    imem_we,    1'b1);
    chk("midrst_pre_wdata", imem_wdata, 32'h44332211);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",   in_ready,   1'b1);
    chk("midrst_imem_we",    imem_we,    1'b0);
    chk("midrst_imem_addr",  imem_addr,  '0);
    chk("midrst_imem_wdata", imem_wdata, 32'd0);
    chk("midrst_core_rst_n", core_rst_n, 1'b0);
    chk("midrst_load_done",  load_done,  1'b0);
    chk("midrst_load_err",   load_err,   1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Leftover data bytes must be ignored until a fresh marker.
    build_frame(2, 1'b0, 0, fb);
    fb.push_front(8'h88); fb.push_front(8'h77); fb.push_front(8'h66); fb.push_front(8'h55);
    run_frame(fb, 1'b0, "postrst");

    // DONE refuses further bytes.
    nacc = aq.size();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk("done_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done_no_accept", aq.size(), nacc);

    // Random frames with idle gaps, garbage prefixes and occasional bad checksums.
    last_done = 1'b1;
    for (int r = 0; r < 12; r++) begin
      if (last_done) do_reset();
      build_frame($urandom_range(1, 8), $urandom_range(0, 2) == 0, $urandom_range(0, 3), fb);
      run_frame(fb, 1'b1, $sformatf("rnd%0d", r));
      last_done = exp_done;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
